// File: rtl/matmul_pkg.sv
// Shared constants, FSM encoding and lane-mask helper for the matmul tile sequencer.
package matmul_pkg;

  localparam int unsigned CW          = 5;
  localparam int unsigned FIRST_DRAIN = 5;
  localparam int unsigned LAST_COUNT  = 11;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } state_e;

  // Lanes of d1..d4 that carry data for anti-diagonal 0..6 (bit0 = d1).
  function automatic logic [3:0] diag_mask(input logic [2:0] diag);
    logic [3:0] mask;
    mask = 4'b0000;
    case (diag)
      3'd0:    mask = 4'b0001;
      3'd1:    mask = 4'b0011;
      3'd2:    mask = 4'b0111;
      3'd3:    mask = 4'b1111;
      3'd4:    mask = 4'b0111;
      3'd5:    mask = 4'b0011;
      3'd6:    mask = 4'b0001;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Job handshake, dispatcher control and writeback tagging signals of the matmul sequencer.
interface matmul_sequencer_if;
  import matmul_pkg::*;

  logic          start;
  logic          accumulate;
  logic          ready;
  logic [CW-1:0] count;
  logic          should_add;
  logic          out_valid;
  logic [3:0]    out_mask;
  logic [2:0]    out_diag;
  logic          wb_ready;
  logic          done;

  modport master (
    output start, accumulate, wb_ready,
    input  ready, count, should_add, out_valid, out_mask, out_diag, done
  );

  modport slave (
    input  start, accumulate, wb_ready,
    output ready, count, should_add, out_valid, out_mask, out_diag, done
  );

endinterface

// File: rtl/matmul_sequencer.sv
// Job-level controller for the 4x4 systolic matmul tile: steps the array, tags each drained
// anti-diagonal for writeback and stalls the step count under writeback backpressure.
module matmul_sequencer
  import matmul_pkg::*;
(
  input logic               clk,
  input logic               rst,
  matmul_sequencer_if.slave bus
);

  localparam logic [CW-1:0] FirstDrain = CW'(FIRST_DRAIN);
  localparam logic [CW-1:0] LastCount  = CW'(LAST_COUNT);

  state_e        state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic          should_add_q, should_add_d;
  logic          out_valid_q, out_valid_d;
  logic [3:0]    out_mask_q, out_mask_d;
  logic [2:0]    out_diag_q, out_diag_d;
  logic          done_q, done_d;

  logic          issue;
  logic          wb_accept;
  logic [2:0]    diag_next;

  always_comb begin
    // A held diagonal blocks the next step until writeback takes it.
    issue     = (state_q == StRun) && (!out_valid_q || bus.wb_ready);
    wb_accept = out_valid_q && bus.wb_ready;
    diag_next = 3'(step_q - FirstDrain);

    state_d      = state_q;
    step_d       = step_q;
    should_add_d = should_add_q;
    out_valid_d  = out_valid_q;
    out_mask_d   = out_mask_q;
    out_diag_d   = out_diag_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d      = StRun;
          step_d       = CW'(1);
          should_add_d = bus.accumulate;
        end
      end
      StRun: begin
        if (issue) begin
          step_d = step_q + CW'(1);
          if (step_q == LastCount) state_d = StFlush;
        end
      end
      StFlush: begin
        if (wb_accept) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Capture and accept on the same edge keeps out_valid high with the next tags.
    if (issue && (step_q >= FirstDrain)) begin
      out_valid_d = 1'b1;
      out_diag_d  = diag_next;
      out_mask_d  = diag_mask(diag_next);
    end else if (wb_accept) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      step_q       <= '0;
      should_add_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_mask_q   <= 4'b0000;
      out_diag_q   <= 3'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      should_add_q <= should_add_d;
      out_valid_q  <= out_valid_d;
      out_mask_q   <= out_mask_d;
      out_diag_q   <= out_diag_d;
      done_q       <= done_d;
    end
  end

  assign bus.ready      = (state_q == StIdle);
  assign bus.count      = issue ? step_q : '0;
  assign bus.should_add = should_add_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_mask   = out_mask_q;
  assign bus.out_diag   = out_diag_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural anti-diagonal dispatcher.
module tb_matmul_sequencer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  logic [3:0]  mask_tab [7] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h7, 4'h3, 4'h1};
  logic [15:0] d [4];

  matmul_sequencer_if bus ();

  matmul_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // r(i,j) = 10*i + j (1-based), a(i,j) = 200 + r(i,j); fpadd modelled as integer add.
  always @(posedge clk) begin
    if (bus.count >= 5) begin
      for (int l = 0; l < 4; l++) begin
        int k, row, col, rv;
        k = int'(bus.count) - 5;
        if (k <= 3) begin
          row = l;
          col = k - l;
        end else begin
          row = l + k - 3;
          col = 3 - l;
        end
        if (col >= 0 && col <= 3 && row <= 3) begin
          rv = 10 * (row + 1) + col + 1;
          d[l] <= 16'(bus.should_add ? (2 * rv + 200) : rv);
        end else begin
          d[l] <= 16'd0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full job with wb_ready tied high; accept edge ends the first cycle of this task.
  task automatic run_job(input logic acc);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.accumulate = acc;
    bus.wb_ready   = 1'b1;
    #1 chk("ready_idle", 32'(bus.ready), 32'd1);
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      chk("count", 32'(bus.count), (c <= 11) ? c : 0);
      chk("valid", 32'(bus.out_valid), 32'((c >= 6) && (c <= 12)));
      if (c >= 6 && c <= 12) begin
        chk("diag", 32'(bus.out_diag), c - 6);
        chk("mask", 32'(bus.out_mask), 32'(mask_tab[c-6]));
      end
      chk("done", 32'(bus.done), 32'(c == 13));
      if (c <= 11) chk("should_add", 32'(bus.should_add), 32'(acc));
      if (c == 6) chk("d1_diag0", 32'(d[0]), acc ? 222 : 11);
      if (c == 9) begin
        chk("d1_diag3", 32'(d[0]), acc ? 228 : 14);
        chk("d2_diag3", 32'(d[1]), acc ? 246 : 23);
        chk("d3_diag3", 32'(d[2]), acc ? 264 : 32);
        chk("d4_diag3", 32'(d[3]), acc ? 282 : 41);
      end
    end
  endtask

  initial begin
    int hs;
    bit got_done;
    errors         = 0;
    checks         = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.accumulate = 1'b0;
    bus.wb_ready   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mask", 32'(bus.out_mask), 32'd0);
    chk("rst_diag", 32'(bus.out_diag), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_should_add", 32'(bus.should_add), 32'd0);
    rst = 1'b0;

    // 1 and 2: plain job, then accumulate job
    run_job(1'b0);
    run_job(1'b1);

    // 3: writeback stall while diagonal 3 is held
    @(negedge clk);
    bus.start = 1'b1;
    bus.accumulate = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1 chk("bp_count", 32'(bus.count), c);
    end
    for (int c = 9; c <= 11; c++) begin
      @(negedge clk);
      bus.wb_ready = 1'b0;
      #1;
      chk("bp_stall_count", 32'(bus.count), 32'd0);
      chk("bp_stall_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_stall_mask", 32'(bus.out_mask), 32'hF);
      chk("bp_stall_diag", 32'(bus.out_diag), 32'd3);
      chk("bp_stall_d1", 32'(d[0]), 32'd228);
      chk("bp_stall_d4", 32'(d[3]), 32'd282);
    end
    @(negedge clk);
    bus.wb_ready = 1'b1;
    #1;
    chk("bp_resume_count", 32'(bus.count), 32'd9);
    chk("bp_resume_diag", 32'(bus.out_diag), 32'd3);
    @(negedge clk);
    #1;
    chk("bp_count10", 32'(bus.count), 32'd10);
    chk("bp_diag4", 32'(bus.out_diag), 32'd4);
    chk("bp_mask4", 32'(bus.out_mask), 32'h7);
    chk("bp_d1_diag4", 32'(d[0]), 32'd248);
    @(negedge clk);
    #1;
    chk("bp_count11", 32'(bus.count), 32'd11);
    chk("bp_diag5", 32'(bus.out_diag), 32'd5);
    @(negedge clk);
    #1;
    chk("bp_flush_count", 32'(bus.count), 32'd0);
    chk("bp_diag6", 32'(bus.out_diag), 32'd6);
    chk("bp_valid6", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    #1 chk("bp_done", 32'(bus.done), 32'd1);

    // 4: start during RUN ignored; start held through done re-launches
    @(negedge clk);
    bus.start = 1'b1;
    bus.accumulate = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = (c == 3) || (c >= 12);
      #1;
      if (c == 3) begin
        chk("busy_ready", 32'(bus.ready), 32'd0);
        chk("busy_count3", 32'(bus.count), 32'd3);
      end
      if (c == 4) chk("busy_count4", 32'(bus.count), 32'd4);
      if (c == 12) chk("flush_ready", 32'(bus.ready), 32'd0);
      if (c == 13) begin
        chk("b2b_done", 32'(bus.done), 32'd1);
        chk("b2b_ready", 32'(bus.ready), 32'd1);
      end
    end
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      if (c <= 11) chk("b2b_count", 32'(bus.count), c);
      if (c == 13) chk("b2b_done2", 32'(bus.done), 32'd1);
    end

    // 5: reset mid-job aborts without done
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 8) rst = 1'b1;
      #1;
      if (c == 8) chk("abort_count8", 32'(bus.count), 32'd8);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_count", 32'(bus.count), 32'd0);
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1 chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    run_job(1'b0);

    // 6: random writeback backpressure
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.wb_ready = 1'($urandom_range(0, 1));
      #1 chk("rand_done_once", 32'(bus.done), 32'd0);
      hs = 0;
      got_done = 1'b0;
      for (int t = 0; t < 400 && !got_done; t++) begin
        @(negedge clk);
        bus.start = 1'b0;
        bus.wb_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.done) begin
          got_done = 1'b1;
        end else if (bus.out_valid && bus.wb_ready) begin
          chk("rand_diag", 32'(bus.out_diag), hs);
          chk("rand_mask", 32'(bus.out_mask), (hs < 7) ? 32'(mask_tab[hs]) : 32'd0);
          hs++;
        end
      end
      chk("rand_got_done", 32'(got_done), 32'd1);
      chk("rand_handshakes", hs, 32'd7);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
